// File: rtl/rgb_pwm_pkg.sv
// Shared definitions for the 8-bit RGB PWM link (transmit and receive ends).
package rgb_pwm_pkg;
  localparam int FRAME_LEN = 256;
  localparam int CODE_W    = 8;
  localparam int CNT_W     = CODE_W + 1;
  localparam int POS_W     = $clog2(FRAME_LEN);
  localparam int NUM_CH    = 3;

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_e;

  // A full-frame high count of 256 means code 255.
  function automatic logic [CODE_W-1:0] sat8(input logic [CNT_W-1:0] v);
    return v[CODE_W] ? {CODE_W{1'b1}} : v[CODE_W-1:0];
  endfunction
endpackage

// File: rtl/rgb_pwm_capture8_duty.sv
// Per-channel high-time counter; latches a saturated duty code at frame end.
module pwm_duty_counter
  import rgb_pwm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_s,
  input  logic              i_clr_load,
  input  logic              i_load_val,
  input  logic              i_end_frame,
  output logic [CNT_W-1:0]  o_count,
  output logic [CODE_W-1:0] o_code
);
  logic [CNT_W-1:0]  r_cnt;
  logic [CODE_W-1:0] r_code;
  logic [CNT_W-1:0]  w_sum;

  assign w_sum = r_cnt + CNT_W'(i_s);

  // Realign load beats frame end: the aborted frame never reports.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_code <= '0;
    end else if (i_clr_load) begin
      r_cnt  <= CNT_W'(i_load_val);
    end else if (i_end_frame) begin
      r_code <= sat8(w_sum);
      r_cnt  <= '0;
    end else begin
      r_cnt  <= w_sum;
    end
  end

  assign o_count = r_cnt;
  assign o_code  = r_code;
endmodule

// File: rtl/rgb_pwm_capture8.sv
// PWM receive end: synchronises R/G/B pins, tracks frame phase from rising edges, recovers duty codes.
module rgb_pwm_capture8
  import rgb_pwm_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MISS_FRAMES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              an,
  input  logic              r_i,
  input  logic              g_i,
  input  logic              b_i,
  output logic [CODE_W-1:0] rcolor_o,
  output logic [CODE_W-1:0] gcolor_o,
  output logic [CODE_W-1:0] bcolor_o,
  output logic              valid_o,
  output logic              locked_o,
  output logic              slip_o
);
  localparam int MW = $clog2(MISS_FRAMES + 1);

  logic [NUM_CH-1:0]                  w_pin;
  logic [NUM_CH-1:0][SYNC_STAGES-1:0] r_sync;
  logic [NUM_CH-1:0]                  w_s;
  logic [NUM_CH-1:0]                  r_s_d;
  logic                               w_rise;
  logic [POS_W-1:0]                   r_pos;
  logic [MW-1:0]                      r_miss, w_miss_nxt;
  logic                               r_seen, w_seen_nxt;
  lock_state_e                        r_state, w_state_nxt;
  logic                               w_realign, w_end, w_slip;
  logic                               r_valid, r_slip;
  logic [NUM_CH-1:0][CNT_W-1:0]       w_count;
  logic [NUM_CH-1:0][CODE_W-1:0]      w_code;
  logic                               w_count_unused;

  assign w_pin = {b_i, g_i, r_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_s_d  <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++)
        r_sync[k] <= {r_sync[k][SYNC_STAGES-2:0], w_pin[k]};
      r_s_d <= w_s;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) w_s[k] = r_sync[k][SYNC_STAGES-1] ^ an;
  end

  // Coincident rises on several channels collapse into one event.
  assign w_rise    = |(w_s & ~r_s_d);
  assign w_realign = w_rise && ((r_state == UNLOCKED) || (r_pos != '0));
  assign w_end     = (r_pos == POS_W'(FRAME_LEN - 1)) && !w_realign;

  always_comb begin
    w_state_nxt = r_state;
    w_miss_nxt  = r_miss;
    w_seen_nxt  = r_seen;
    w_slip      = 1'b0;
    case (r_state)
      UNLOCKED: begin
        if (w_rise) begin
          w_state_nxt = LOCKED;
          w_miss_nxt  = '0;
          w_seen_nxt  = 1'b1;
        end
      end
      LOCKED: begin
        if (w_realign) begin
          w_slip     = 1'b1;
          w_miss_nxt = '0;
          w_seen_nxt = 1'b1;
        end else begin
          if (w_rise) w_seen_nxt = 1'b1;
          if (w_end) begin
            w_seen_nxt = 1'b0;
            if (r_seen) begin
              w_miss_nxt = '0;
            end else begin
              w_miss_nxt = r_miss + MW'(1);
              if (r_miss + MW'(1) >= MW'(MISS_FRAMES)) w_state_nxt = UNLOCKED;
            end
          end
        end
      end
      default: w_state_nxt = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= UNLOCKED;
      r_pos   <= '0;
      r_miss  <= '0;
      r_seen  <= 1'b0;
      r_valid <= 1'b0;
      r_slip  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pos   <= w_realign ? POS_W'(1) : r_pos + POS_W'(1);
      r_miss  <= w_miss_nxt;
      r_seen  <= w_seen_nxt;
      r_valid <= w_end;
      r_slip  <= w_slip;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    pwm_duty_counter u_cnt (
      .clk         (clk),
      .rst         (rst),
      .i_s         (w_s[k]),
      .i_clr_load  (w_realign),
      .i_load_val  (w_s[k]),
      .i_end_frame (w_end),
      .o_count     (w_count[k]),
      .o_code      (w_code[k])
    );
  end

  assign w_count_unused = ^w_count;

  assign rcolor_o = w_code[0];
  assign gcolor_o = w_code[1];
  assign bcolor_o = w_code[2];
  assign valid_o  = r_valid;
  assign locked_o = (r_state == LOCKED);
  assign slip_o   = r_slip;
endmodule

// File: tb/tb_rgb_pwm_capture8.sv
// Randomised bench for rgb_pwm_capture8: frame-window reference model feeding a scoreboard.
module tb_rgb_pwm_capture8;
  localparam int S     = 2;
  localparam int MISSF = 4;

  logic clk = 1'b0, rst = 1'b1, an = 1'b0;
  logic r_i = 1'b0, g_i = 1'b0, b_i = 1'b0;
  logic [7:0] rcolor_o, gcolor_o, bcolor_o;
  logic valid_o, locked_o, slip_o;

  rgb_pwm_capture8 #(.SYNC_STAGES(S), .MISS_FRAMES(MISSF)) dut (
    .clk(clk), .rst(rst), .an(an), .r_i(r_i), .g_i(g_i), .b_i(b_i),
    .rcolor_o(rcolor_o), .gcolor_o(gcolor_o), .bcolor_o(bcolor_o),
    .valid_o(valid_o), .locked_o(locked_o), .slip_o(slip_o)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int edge_cnt;
  always @(posedge clk or posedge rst)
    if (rst) edge_cnt <= 0; else edge_cnt <= edge_cnt + 1;

  typedef struct { int e; int r; int g; int b; } exp_t;
  exp_t      expq[$];
  bit        exp_lock[int];
  bit        exp_slip[int];
  logic [2:0] pinh[int];
  logic [2:0] levh[int];

  int   frame_start;
  bit   m_locked, m_seen;
  int   m_miss;
  int   code[3], ph[3];
  logic [2:0] force_hi = 3'b000;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic bit pwm(input int cd, input int p, input int c);
    int q;
    q = (((c - p) % 256) + 256) % 256;
    if (cd <= 0) return 1'b0;
    if (cd >= 255) return 1'b1;
    return q < cd;
  endfunction

  // Receiver sees pin[e-S]^an at edge e; a frame's code is the high count over its 256 samples.
  task automatic model_step(input int e);
    logic [2:0] lev, prev;
    int pos, sum[3];
    bit rise, slip;
    exp_t x;
    lev  = ((e >= S) ? pinh[e-S] : 3'b000) ^ {3{an}};
    prev = (e > 0) ? levh[e-1] : 3'b000;
    levh[e] = lev;
    rise = |(lev & ~prev);
    pos  = (e - frame_start) % 256;
    slip = 1'b0;
    if (rise && (!m_locked || pos != 0)) begin
      slip = m_locked;
      frame_start = e;
      m_locked = 1'b1; m_miss = 0; m_seen = 1'b1;
    end else begin
      if (rise) m_seen = 1'b1;
      if (pos == 255) begin
        for (int k = 0; k < 3; k++) begin
          sum[k] = 0;
          for (int t = e - 255; t <= e; t++) sum[k] += levh[t][k];
          if (sum[k] > 255) sum[k] = 255;
        end
        x.e = e; x.r = sum[0]; x.g = sum[1]; x.b = sum[2];
        expq.push_back(x);
        if (m_locked) begin
          if (m_seen) m_miss = 0; else m_miss++;
          m_seen = 1'b0;
          if (m_miss >= MISSF) m_locked = 1'b0;
        end
      end
    end
    exp_lock[e] = m_locked;
    exp_slip[e] = slip;
  endtask

  task automatic drive_one();
    int c;
    logic [2:0] gv, pins;
    c = edge_cnt;
    for (int k = 0; k < 3; k++) gv[k] = pwm(code[k], ph[k], c);
    gv   = gv | force_hi;
    pins = gv ^ {3{an}};
    {b_i, g_i, r_i} = pins;
    pinh[c] = pins;
    model_step(c);
  endtask

  task automatic drive(input int n);
    repeat (n) begin
      drive_one();
      @(negedge clk);
    end
  endtask

  task automatic drive_to_pos(input int p);
    for (int i = 0; i < 256; i++) begin
      if (((edge_cnt - frame_start) % 256) == p) break;
      drive(1);
    end
  endtask

  task automatic set_codes(input int r, input int g, input int b);
    code[0] = r; code[1] = g; code[2] = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_r", rcolor_o, 0);
    check("rst_g", gcolor_o, 0);
    check("rst_b", bcolor_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_locked", locked_o, 0);
    check("rst_slip", slip_o, 0);
    repeat (3) @(negedge clk);
    expq.delete(); exp_lock.delete(); exp_slip.delete();
    pinh.delete(); levh.delete();
    frame_start = 0; m_locked = 1'b0; m_miss = 0; m_seen = 1'b0;
    rst = 1'b0;
  endtask

  // Scoreboard monitor: one look per cycle, after the edge it judges.
  always @(negedge clk) begin
    int le;
    exp_t x;
    if (!rst && edge_cnt > 0) begin
      le = edge_cnt - 1;
      if (exp_lock.exists(le)) begin
        check("locked", locked_o, exp_lock[le]);
        check("slip", slip_o, exp_slip[le]);
      end
      if (valid_o) begin
        if (expq.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL valid: strobe after edge %0d, none expected", le);
        end else begin
          x = expq.pop_front();
          check("valid_edge", le, x.e);
          check("rcolor", rcolor_o, x.r);
          check("gcolor", gcolor_o, x.g);
          check("bcolor", bcolor_o, x.b);
        end
      end else if (expq.size() > 0 && expq[0].e <= le) begin
        vectors++; miscompares++;
        $display("FAIL valid: no strobe after edge %0d, expected 1", expq[0].e);
        void'(expq.pop_front());
      end
    end
  end

  initial begin
    ph = '{0, 0, 0};
    set_codes(0, 0, 0);
    do_reset();

    // Steady codes, shared phase: locks, no slips.
    ph = '{40, 40, 40};
    set_codes(128, 1, 254);
    drive(256 * 6);
    check("t1_r", rcolor_o, 128);
    check("t1_g", gcolor_o, 1);
    check("t1_b", bcolor_o, 254);
    check("t1_locked", locked_o, 1);

    // Constant levels: all low, then all high (one startup rise only).
    set_codes(0, 0, 0);
    do_reset();
    drive(256 * 3);
    check("t2_lock0", locked_o, 0);
    check("t2_r0", rcolor_o, 0);
    set_codes(255, 255, 255);
    drive(256 * 7);
    check("t2_r255", rcolor_o, 255);
    check("t2_b255", bcolor_o, 255);
    check("t2_lock255", locked_o, 0);

    // Lock on red, then go dark until lock is lost.
    set_codes(0, 0, 0);
    do_reset();
    set_codes(100, 0, 0);
    drive(256 * 3);
    check("t3_locked", locked_o, 1);
    set_codes(0, 0, 0);
    drive(256 * 7);
    check("t3_unlocked", locked_o, 0);
    check("t3_r", rcolor_o, 0);

    // Extra edge mid-frame while locked.
    set_codes(10, 60, 30);
    drive(256 * 3);
    drive_to_pos(37);
    force_hi = 3'b001;
    drive(3);
    force_hi = 3'b000;
    drive(256 * 4);
    check("t4_r", rcolor_o, 10);
    check("t4_g", gcolor_o, 60);

    // Anode mode: inverted pins.
    an = 1'b1;
    set_codes(0, 200, 0);
    drive(256 * 4);
    check("t5_g", gcolor_o, 200);

    // Reset mid-frame, then randomised runs.
    an = 1'b0;
    set_codes($urandom_range(1, 254), $urandom_range(1, 254), $urandom_range(1, 254));
    drive(256 * 2);
    drive_to_pos(120);
    do_reset();
    drive(256 * 3);

    for (int it = 0; it < 6; it++) begin
      int p;
      an = 1'($urandom_range(0, 1));
      for (int k = 0; k < 3; k++) begin
        case ($urandom_range(0, 5))
          0:       code[k] = 0;
          1:       code[k] = 255;
          default: code[k] = $urandom_range(1, 254);
        endcase
      end
      p = $urandom_range(0, 255);
      for (int k = 0; k < 3; k++)
        ph[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : p;
      if (it == 3) do_reset();
      drive(256 * $urandom_range(3, 5) + $urandom_range(0, 255));
    end
    drive(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
